// File: rtl/systolic_edge_feeder_if.sv
// Operand beat handshake and array-edge bundle
// between the job source and the systolic feeder.
interface systolic_edge_feeder_if #(
    parameter int N = 4
);
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [N*8-1:0] in_a;
    logic [N*8-1:0] in_b;
    logic [N*8-1:0] a_edge;
    logic [N*8-1:0] b_edge;
    logic           array_clr;
    logic           mode;
    logic           drain_valid;
    logic           busy;
    logic           done;

    modport master (
        output start, in_valid, in_last, in_a, in_b,
        input  in_ready, a_edge, b_edge, array_clr,
        input  mode, drain_valid, busy, done
    );

    modport slave (
        input  start, in_valid, in_last, in_a, in_b,
        output in_ready, a_edge, b_edge, array_clr,
        output mode, drain_valid, busy, done
    );
endinterface

// File: rtl/systolic_edge_feeder.sv
// Feeder/sequencer for an NxN systolic array:
// skews operand lanes and runs clear/feed/flush/drain.
module systolic_edge_feeder #(
    parameter int N         = 4,
    parameter int FLUSH_CYC = 2*N+1
) (
    input logic                  clk,
    input logic                  rst,
    systolic_edge_feeder_if.slave bus
);
    localparam int FW = $clog2(FLUSH_CYC+1);
    localparam int DW = $clog2(N+1);
    localparam logic [FW-1:0] F_END = FW'(FLUSH_CYC-1);
    localparam logic [DW-1:0] D_END = DW'(N-1);
    localparam logic [DW-1:0] D_PRE = DW'(N-2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    logic [DW-1:0] dcnt;
    logic          ready_q;
    logic          clr_q;
    logic          mode_q;
    logic          dv_q;
    logic          busy_q;
    logic          done_q;
    logic          accept;

    assign accept = bus.in_valid & ready_q;

    assign bus.in_ready    = ready_q;
    assign bus.array_clr   = clr_q;
    assign bus.mode        = mode_q;
    assign bus.drain_valid = dv_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // Idle cycles push zeros so gaps shift every lane uniformly.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] pa [0:i];
        logic [7:0] pb [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    pa[j] <= 8'd0;
                    pb[j] <= 8'd0;
                end
            end else begin
                pa[0] <= accept ? bus.in_a[8*i +: 8] : 8'd0;
                pb[0] <= accept ? bus.in_b[8*i +: 8] : 8'd0;
                for (int j = 1; j <= i; j++) begin
                    pa[j] <= pa[j-1];
                    pb[j] <= pb[j-1];
                end
            end
        end

        assign bus.a_edge[8*i +: 8] = pa[i];
        assign bus.b_edge[8*i +: 8] = pb[i];
    end

    // Outputs are set alongside the transition into each state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fcnt    <= '0;
            dcnt    <= '0;
            ready_q <= 1'b0;
            clr_q   <= 1'b0;
            mode_q  <= 1'b0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= CLEAR;
                        clr_q  <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    state   <= FEED;
                    clr_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
                FEED: begin
                    if (accept && bus.in_last) begin
                        state   <= FLUSH;
                        ready_q <= 1'b0;
                        fcnt    <= '0;
                    end
                end
                FLUSH: begin
                    if (fcnt == F_END) begin
                        state  <= DRAIN;
                        mode_q <= 1'b1;
                        dv_q   <= 1'b1;
                        dcnt   <= '0;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == D_END) begin
                        state  <= IDLE;
                        mode_q <= 1'b0;
                        dv_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        dcnt   <= dcnt + DW'(1);
                        done_q <= (dcnt == D_PRE);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
